// File: rtl/vga_box_scheduler.sv
// Round-robin redraw scheduler: fills one of 8 BOX_SIZE^2 boxes per grant into the vga_adapter port.
// Latency: ack and first write one cycle after req is seen in IDLE, done 1024 cycles after ack.
// Backpressure: none downstream; req is level-held until ack. Define VGA_BOX_BORDER_EN for white borders.
module vga_box_scheduler #(
  parameter int nX        = 10,
  parameter int nY        = 9,
  parameter int NUM_BOXES = 8,
  parameter int BOX_SIZE  = 32,
  parameter int X_FIRST   = 40,
  parameter int X_PITCH   = 80,
  parameter int Y_CENTER  = 240
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_BOXES-1:0]   req,
  input  logic [9*NUM_BOXES-1:0] req_color,
  output logic [NUM_BOXES-1:0]   ack,
  output logic                   busy,
  output logic                   done,
  output logic [nX-1:0]          vga_x,
  output logic [nY-1:0]          vga_y,
  output logic [8:0]             vga_color,
  output logic                   vga_write
);
  localparam int IW = $clog2(NUM_BOXES);
  localparam int CW = $clog2(BOX_SIZE);
  localparam logic [CW-1:0]        C_MAX    = CW'(BOX_SIZE - 1);
  localparam logic [nX-1:0]        X_LEFT0  = nX'(X_FIRST - BOX_SIZE / 2);
  localparam logic [nX-1:0]        X_STEP   = nX'(X_PITCH);
  localparam logic [nY-1:0]        Y_TOP    = nY'(Y_CENTER - BOX_SIZE / 2);
  localparam logic [NUM_BOXES-1:0] ONE_HOT0 = NUM_BOXES'(1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last, cand, grant_idx;
  logic          grant_vld;
  logic [CW-1:0] cx, cy;
  logic [8:0]    col, pix_color;
  logic [nX-1:0] base_x;
  logic          last_pix;
  logic [8:0]    slot_color [NUM_BOXES];

  always_comb begin
    for (int i = 0; i < NUM_BOXES; i++) begin
      slot_color[i] = req_color[9*i +: 9];
    end
  end

  // Search starts just past the previous winner; k == NUM_BOXES wraps back to last itself.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last;
    cand      = last;
    for (int k = 1; k <= NUM_BOXES; k++) begin
      cand = last + IW'(k);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign last_pix = (cx == C_MAX) && (cy == C_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = DRAW;
      DRAW:    if (last_pix)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      last   <= IW'(NUM_BOXES - 1);
      cx     <= '0;
      cy     <= '0;
      col    <= '0;
      base_x <= '0;
      ack    <= '0;
    end else begin
      ack <= '0;
      if (state == IDLE && grant_vld) begin
        ack    <= ONE_HOT0 << grant_idx;
        last   <= grant_idx;
        col    <= slot_color[grant_idx];
        cx     <= '0;
        cy     <= '0;
        base_x <= X_LEFT0 + nX'(grant_idx) * X_STEP;
      end else if (state == DRAW) begin
        cx <= cx + 1'b1;
        if (cx == C_MAX) cy <= cy + 1'b1;
      end
    end
  end

`ifdef VGA_BOX_BORDER_EN
  always_comb begin
    pix_color = col;
    if (cx == '0 || cx == C_MAX || cy == '0 || cy == C_MAX) pix_color = 9'h1FF;
  end
`else
  assign pix_color = col;
`endif

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    vga_write = (state == DRAW);
    vga_x     = '0;
    vga_y     = '0;
    vga_color = '0;
    if (state == DRAW) begin
      vga_x     = base_x + nX'(cx);
      vga_y     = Y_TOP + nY'(cy);
      vga_color = pix_color;
    end
  end
endmodule

// File: tb/tb_vga_box_scheduler.sv
// Scoreboard bench for vga_box_scheduler: a round-robin/geometry model predicts grants and pixel streams.
module tb_vga_box_scheduler;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req = '0;
  logic [71:0] req_color = '0;
  logic [7:0]  ack;
  logic        busy, done, vga_write;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [8:0]  vga_color;

  vga_box_scheduler dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req),
    .req_color(req_color),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_color(vga_color),
    .vga_write(vga_write)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         box;
    logic [8:0] col;
  } grant_t;

  int          n_tests = 0;
  int          n_fail = 0;
  grant_t      grant_q[$];
  logic [27:0] pix_q[$];
  int          m_last = 7;
  logic [7:0]  pending = '0;
  logic [7:0]  inject_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference arbitration: first requester after the last winner, wrapping modulo 8.
  function automatic int pick(input logic [7:0] m, input int last);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (last + k) % 8;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: expands each observed grant into the expected raster of pixels.
  initial begin
    int          cyc, ack_cyc, wr_cnt;
    bit          in_box, chk_idle;
    grant_t      g;
    logic [27:0] e;
    logic [8:0]  c;
    cyc = 0; ack_cyc = 0; wr_cnt = 0; in_box = 0; chk_idle = 0;
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (reset) begin
        pix_q.delete();
        in_box   = 0;
        chk_idle = 0;
      end else begin
        if (chk_idle) begin
          chk("busy_after_done", busy, 0);
          chk_idle = 0;
        end
        if (ack != 0) begin
          if (grant_q.size() == 0) fail_now("unexpected_ack");
          else begin
            g = grant_q.pop_front();
            chk("ack_onehot", ack, 32'(1) << g.box);
            pix_q.delete();
            for (int r = 0; r < 32; r++) begin
              for (int cc = 0; cc < 32; cc++) begin
                c = g.col;
`ifdef VGA_BOX_BORDER_EN
                if (r == 0 || r == 31 || cc == 0 || cc == 31) c = 9'h1FF;
`endif
                e = {10'(40 + g.box * 80 - 16 + cc), 9'(240 - 16 + r), c};
                pix_q.push_back(e);
              end
            end
            in_box  = 1;
            ack_cyc = cyc;
            wr_cnt  = 0;
          end
        end
        if (vga_write) begin
          if (pix_q.size() == 0) fail_now("unexpected_write");
          else begin
            if (wr_cnt == 0) chk("first_write_latency", cyc - ack_cyc, 0);
            e = pix_q.pop_front();
            chk("pixel_xyc", {vga_x, vga_y, vga_color}, e);
            wr_cnt++;
          end
        end
        if (done) begin
          if (!in_box) fail_now("unexpected_done");
          else begin
            chk("write_count", wr_cnt, 1024);
            chk("done_latency", cyc - ack_cyc, 1024);
            in_box   = 0;
            chk_idle = 1;
          end
        end
      end
    end
  end

  task automatic do_reset(input bit check);
    reset   = 1'b1;
    req     = '0;
    pending = '0;
    repeat (3) @(negedge CLOCK_50);
    if (check) begin
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_write", vga_write, 0);
      chk("rst_x", vga_x, 0);
      chk("rst_y", vga_y, 0);
      chk("rst_color", vga_color, 0);
    end
    reset  = 1'b0;
    m_last = 7;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK_50);
      if (busy === 1'b0) return;
    end
    fail_now("idle_timeout");
  endtask

  // Scrambles colours mid-draw and optionally raises extra requests while the box is drawing.
  task automatic wait_done();
    for (int i = 0; i < 1100; i++) begin
      if (i == 100) begin
        req_color = 72'({$urandom(), $urandom(), $urandom()});
        if (inject_mask != 0) begin
          pending     = pending | inject_mask;
          req         = pending;
          inject_mask = '0;
        end
      end
      if (done === 1'b1) return;
      @(negedge CLOCK_50);
    end
    fail_now("done_timeout");
  endtask

  task automatic issue_grant(output int b);
    grant_t gt;
    req = pending;
    b = pick(pending, m_last);
    gt.box = b;
    gt.col = req_color[9*b +: 9];
    grant_q.push_back(gt);
    m_last = b;
    @(negedge CLOCK_50);
    pending[b] = 1'b0;
    req = pending;
  endtask

  task automatic serve_all();
    int b;
    while (pending != 0) begin
      wait_idle();
      issue_grant(b);
      wait_done();
    end
  endtask

  initial begin
    #5_000_000;
    fail_now("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int b;
    do_reset(1);
    @(negedge CLOCK_50);
    chk("idle_after_release_busy", busy, 0);

    // Single box 0 in colour 070; colours scrambled mid-draw.
    req_color[8:0] = 9'h070;
    pending = 8'h01;
    serve_all();

    // All slots held from reset: expected order 0..7.
    do_reset(0);
    req_color = 72'({$urandom(), $urandom(), $urandom()});
    pending = 8'hFF;
    serve_all();

    // Box 3 first, boxes 5 and 1 raised while it draws.
    do_reset(0);
    pending = 8'h08;
    inject_mask = 8'h22;
    serve_all();

    // Reset in the middle of box 2.
    do_reset(0);
    pending = 8'h04;
    wait_idle();
    issue_grant(b);
    repeat (499) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("mid_rst_write", vga_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    reset  = 1'b0;
    m_last = 7;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk("no_done_after_rst", done, 0);
    end
    pending = 8'h04;
    serve_all();

    // Randomized request masks with random mid-draw arrivals.
    for (int r = 0; r < 4; r++) begin
      req_color   = 72'({$urandom(), $urandom(), $urandom()});
      pending     = 8'($urandom_range(1, 255));
      inject_mask = 8'($urandom_range(0, 255));
      serve_all();
      if (inject_mask != 0) begin
        pending = inject_mask;
        inject_mask = '0;
        serve_all();
      end
    end

    repeat (5) @(negedge CLOCK_50);
    chk("grant_q_drained", grant_q.size(), 0);
    chk("pix_q_drained", pix_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
